// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer: data width and the
// 2-bit saturating counter encodings.
package branch_target_buffer_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // New entries start weakly taken so one not-taken outcome flips the prediction.
    localparam logic [1:0] CTR_ALLOC = WT;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state function of a 2-bit saturating branch-direction counter.
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    // Step toward strong-taken on taken, toward strong-not-taken otherwise.
    always_comb begin
        ctr_o = ctr_i;
        case (ctr_i)
            SNT:     ctr_o = taken_i ? WNT : SNT;
            WNT:     ctr_o = taken_i ? WT  : SNT;
            WT:      ctr_o = taken_i ? ST  : WNT;
            ST:      ctr_o = taken_i ? ST  : WT;
            default: ctr_o = SNT;
        endcase
    end

endmodule

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer held in flops: zero-latency
// lookup for the fetch PC, one execute-stage update per cycle.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] btb_target_pc,
    output logic            btb_pc_valid,
    output logic            btb_pc_predictTaken,
    input  logic            update_en,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = XLEN - 2 - IDXW;

    logic            valid_q  [SETS][WAYS];
    logic [TAGW-1:0] tag_q    [SETS][WAYS];
    logic [XLEN-1:0] target_q [SETS][WAYS];
    logic [1:0]      ctr_q    [SETS][WAYS];
    logic            lru_q    [SETS];

    logic [IDXW-1:0] rd_idx_s, up_idx_s;
    logic [TAGW-1:0] rd_tag_s, up_tag_s;
    logic            rd_hit0_s, rd_hit1_s, up_hit0_s, up_hit1_s;
    logic            hit_way_s, victim_way_s, wr_way_s;
    logic            ctr_we_s, tgt_we_s;
    logic [1:0]      ctr_cur_s, ctr_nxt_s, ctr_d;
    logic            unused_s;

    assign unused_s  = ^{pc[1:0], update_pc[1:0]};

    assign rd_idx_s  = pc[2 +: IDXW];
    assign rd_tag_s  = pc[XLEN-1 -: TAGW];
    assign up_idx_s  = update_pc[2 +: IDXW];
    assign up_tag_s  = update_pc[XLEN-1 -: TAGW];

    assign rd_hit0_s = valid_q[rd_idx_s][0] && (tag_q[rd_idx_s][0] == rd_tag_s);
    assign rd_hit1_s = valid_q[rd_idx_s][1] && (tag_q[rd_idx_s][1] == rd_tag_s);
    assign up_hit0_s = valid_q[up_idx_s][0] && (tag_q[up_idx_s][0] == up_tag_s);
    assign up_hit1_s = valid_q[up_idx_s][1] && (tag_q[up_idx_s][1] == up_tag_s);

    assign ctr_cur_s = ctr_q[up_idx_s][hit_way_s];

    sat_counter2 u_ctr (
        .ctr_i   (ctr_cur_s),
        .taken_i (update_taken),
        .ctr_o   (ctr_nxt_s)
    );

    // Lookup mux; way 0 wins if both ways ever match, a miss drives zeros.
    always_comb begin
        btb_pc_valid        = 1'b0;
        btb_pc_predictTaken = 1'b0;
        btb_target_pc       = {XLEN{1'b0}};
        if (rd_hit0_s) begin
            btb_pc_valid        = 1'b1;
            btb_pc_predictTaken = ctr_q[rd_idx_s][0][1];
            btb_target_pc       = target_q[rd_idx_s][0];
        end else if (rd_hit1_s) begin
            btb_pc_valid        = 1'b1;
            btb_pc_predictTaken = ctr_q[rd_idx_s][1][1];
            btb_target_pc       = target_q[rd_idx_s][1];
        end else begin
            btb_pc_valid        = 1'b0;
        end
    end

    // Update decode: pick the hit way or a victim, and the counter value to write.
    always_comb begin
        hit_way_s    = up_hit0_s ? 1'b0 : 1'b1;
        victim_way_s = lru_q[up_idx_s];
        if (!valid_q[up_idx_s][0]) begin
            victim_way_s = 1'b0;
        end else if (!valid_q[up_idx_s][1]) begin
            victim_way_s = 1'b1;
        end else begin
            victim_way_s = lru_q[up_idx_s];
        end
        if (up_hit0_s || up_hit1_s) begin
            wr_way_s = hit_way_s;
            ctr_d    = ctr_nxt_s;
            ctr_we_s = update_en;
        end else begin
            wr_way_s = victim_way_s;
            ctr_d    = CTR_ALLOC;
            ctr_we_s = update_en && update_taken;
        end
        tgt_we_s = update_en && update_taken;
    end

    // Valid, counter and LRU state; the LRU bit points at the way not just written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                lru_q[s] <= 1'b0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= SNT;
                end
            end
        end else if (ctr_we_s) begin
            valid_q[up_idx_s][wr_way_s] <= 1'b1;
            ctr_q[up_idx_s][wr_way_s]   <= ctr_d;
            lru_q[up_idx_s]             <= ~wr_way_s;
        end
    end

    // Tag and target payload; no reset needed since valid bits gate their use.
    always_ff @(posedge clk) begin
        if (tgt_we_s && rst_n) begin
            tag_q[up_idx_s][wr_way_s]    <= up_tag_s;
            target_q[up_idx_s][wr_way_s] <= update_target;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer (SETS=8).
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] btb_target_pc;
    logic        btb_pc_valid;
    logic        btb_pc_predictTaken;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        tk;
        logic [31:0] lpc;
        logic        ev;
        logic        ep;
        logic [31:0] et;
    } vec_t;

    vec_t vecs[$];

    branch_target_buffer #(.SETS(8), .WAYS(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pc                  (pc),
        .btb_target_pc       (btb_target_pc),
        .btb_pc_valid        (btb_pc_valid),
        .btb_pc_predictTaken (btb_pc_predictTaken),
        .update_en           (update_en),
        .update_pc           (update_pc),
        .update_target       (update_target),
        .update_taken        (update_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_look(input string nm, input logic ev, input logic ep, input logic [31:0] et);
        chk({nm, ".valid"},  {31'd0, btb_pc_valid}, {31'd0, ev});
        chk({nm, ".taken"},  {31'd0, btb_pc_predictTaken}, {31'd0, ep});
        chk({nm, ".target"}, btb_target_pc, et);
    endtask

    task automatic add(input logic en, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic tk, input logic [31:0] lpc,
                       input logic ev, input logic ep, input logic [31:0] et);
        vec_t v;
        v.en = en; v.upc = upc; v.utgt = utgt; v.tk = tk;
        v.lpc = lpc; v.ev = ev; v.ep = ep; v.et = et;
        vecs.push_back(v);
    endtask

    initial begin
        // Each row is one cycle: the lookup is sampled before the edge that commits the update.
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
        add(1'b1, 32'h100, 32'h200, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b1, 32'h100, 32'h999, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b1, 32'h100, 32'h999, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200);
        add(1'b1, 32'h100, 32'h999, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200);
        add(1'b1, 32'h100, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200);
        add(1'b1, 32'h100, 32'h200, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200);
        add(1'b1, 32'h100, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b1, 32'h100, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b1, 32'h100, 32'h999, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h103, 1'b1, 1'b1, 32'h200);
        add(1'b1, 32'h100, 32'h300, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h300);
        add(1'b1, 32'h120, 32'h520, 1'b1, 32'h120, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h120, 1'b1, 1'b1, 32'h520);
        add(1'b1, 32'h100, 32'h300, 1'b1, 32'h100, 1'b1, 1'b1, 32'h300);
        add(1'b1, 32'h140, 32'h540, 1'b1, 32'h140, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h120, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h300);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h140, 1'b1, 1'b1, 32'h540);
        add(1'b1, 32'h104, 32'h800, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h104, 1'b1, 1'b1, 32'h800);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h124, 1'b0, 1'b0, 32'h0);
        add(1'b1, 32'h400, 32'h444, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h400, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h300);
        add(1'b0, 32'h500, 32'h555, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h500, 1'b0, 1'b0, 32'h0);
        add(1'b1, 32'h140, 32'h999, 1'b0, 32'h140, 1'b1, 1'b1, 32'h540);
        add(1'b0, 32'h0,   32'h0,   1'b0, 32'h140, 1'b1, 1'b0, 32'h540);

        rst_n = 1'b0; pc = 32'h100;
        update_en = 1'b0; update_pc = 32'h0; update_target = 32'h0; update_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_look("in_reset", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            update_en = vecs[i].en; update_pc = vecs[i].upc;
            update_target = vecs[i].utgt; update_taken = vecs[i].tk;
            pc = vecs[i].lpc;
            #2;
            chk_look($sformatf("vec%0d", i), vecs[i].ep === 1'bx ? 1'b0 : vecs[i].ev,
                     vecs[i].ep, vecs[i].et);
        end

        // Asynchronous reset with an update pending: lookups miss at once, update is dropped.
        @(negedge clk);
        update_en = 1'b1; update_pc = 32'h600; update_target = 32'h660; update_taken = 1'b1;
        pc = 32'h100;
        #1;
        chk_look("pre_rst", 1'b1, 1'b1, 32'h300);
        rst_n = 1'b0;
        #1;
        chk_look("rst_0x100", 1'b0, 1'b0, 32'h0);
        pc = 32'h104;
        #1;
        chk_look("rst_0x104", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        update_en = 1'b0;
        pc = 32'h600;
        #2;
        chk_look("rst_drop_0x600", 1'b0, 1'b0, 32'h0);
        pc = 32'h140;
        #1;
        chk_look("rst_0x140", 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter SETS, default 8, number of sets (power of two, at least 2).
REQ-002 SHALL have parameter WAYS, fixed at 2, ways per set.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port pc  input  32  fetch-stage PC being looked up.
REQ-006 SHALL have port btb_target_pc  output  32  predicted target for pc.
REQ-007 SHALL have port btb_pc_valid  output  1  pc hits a valid entry.
REQ-008 SHALL have port btb_pc_predictTaken  output  1  MSB of the hit entry's 2-bit counter.
REQ-009 SHALL have port update_en  input  1  resolved branch/jump from execute this cycle.
REQ-010 SHALL have port update_pc  input  32  PC of the resolved instruction.
REQ-011 SHALL have port update_target  input  32  resolved target address.
REQ-012 SHALL have port update_taken  input  1  resolved direction.

Function
REQ-013 SHALL derive index = pc[2+log2(SETS)-1:2] and tag = pc[31:2+log2(SETS)]; pc[1:0] SHALL be ignored.
REQ-014 SHALL perform lookup combinationally (zero latency): hit = valid and tag match in either way.
REQ-015 On a miss, SHALL drive btb_pc_valid=0, btb_pc_predictTaken=0 and btb_target_pc=0.
REQ-016 Each entry SHALL hold: valid, tag, 32-bit target, 2-bit saturating counter.
REQ-017 Counter states SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 Taken SHALL increment the counter, saturating at 11; not-taken SHALL decrement it, saturating at 00.
REQ-019 On an update hit, SHALL update the counter; if update_taken=1, SHALL also rewrite the target.
REQ-020 On an update miss with update_taken=1, SHALL allocate an entry: valid=1, tag, target, counter=10.
REQ-021 On an update miss with update_taken=0, SHALL leave all state unchanged.
REQ-022 Victim selection SHALL be: invalid way 0 first, then invalid way 1, else the LRU way.
REQ-023 Each set SHALL have one LRU bit, set on every update hit or allocation to point at the other way; lookups SHALL NOT change LRU.
REQ-024 When a lookup and an update hit the same entry in the same cycle, the lookup SHALL return the pre-update contents; the new contents SHALL be visible from the next cycle.
REQ-025 If both ways match a tag (illegal state), way 0 SHALL win; allocation SHALL never create duplicate tags.
REQ-026 At most one update SHALL be processed per cycle; update inputs SHALL be ignored when update_en=0.

Reset
REQ-027 rst_n low SHALL asynchronously clear all valid bits, all counters to 00, and all LRU bits to 0.
REQ-028 During reset, outputs SHALL be btb_pc_valid=0, btb_pc_predictTaken=0, btb_target_pc=0.
REQ-029 Assertion of reset mid-update SHALL discard that update; tags and targets need not be cleared.

Structure
REQ-030 The shared package SHALL hold the counter-state constants (SNT/WNT/WT/ST), the allocation value WT, and XLEN=32.
REQ-031 Counter next-state logic SHALL be one sub-module, sat_counter2 (2-bit in, taken in, 2-bit out, combinational).
REQ-032 Storage SHALL be flops (no SRAM macro) so that lookup is asynchronous.

Verification
REQ-033 Reset, then lookup pc=0x100 -> valid=0, predictTaken=0, target=0.
REQ-034 Update pc=0x100, target=0x200, taken=1; next cycle lookup 0x100 -> valid=1, predictTaken=1, target=0x200, counter=10.
REQ-035 Two more not-taken updates to 0x100 -> counter 01 then 00, predictTaken=0; a third not-taken update keeps 00. Four taken updates -> saturates at 11.
REQ-036 SETS=8: allocate 0x100, then 0x120 (same set), then touch 0x100, then allocate 0x140 -> 0x120 is evicted, 0x100 and 0x140 hit.
REQ-037 Lookup 0x100 while updating 0x100 with target=0x300 -> same cycle shows old target 0x200; next cycle shows 0x300.
REQ-038 Not-taken update to a miss pc 0x400 -> no allocation, lookup 0x400 still misses; async rst_n pulse mid-sequence -> all lookups miss immediately.
